// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch-stage controller: address/data widths,
// reset PC, fetch stride and FSM state encodings.
`ifndef FETCH_DATA_W
`define FETCH_DATA_W 64
`endif

package fetch_ctrl_pkg;

    localparam int          ADDR_W      = 32;
    localparam int          DATA_W      = `FETCH_DATA_W;
    localparam logic [31:0] START_ADDR  = 32'h1C00_0000;
    localparam int          FETCH_BYTES = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_out_buf.sv
// Single-entry output register between fetch and decode. A flush empties it,
// a load fills it, and decode drains it by raising ready while it is valid.
module fetch_out_buf #(
    parameter int AW = 32,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          load,
    input  logic [AW-1:0] load_pc,
    input  logic [DW-1:0] load_inst,
    input  logic          load_adef,
    input  logic          ready,
    output logic          valid,
    output logic [AW-1:0] pc,
    output logic [DW-1:0] inst,
    output logic          adef
);

    // Flush beats a same-cycle load; a load beats a same-cycle drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            pc    <= '0;
            inst  <= '0;
            adef  <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            inst  <= load_inst;
            adef  <= load_adef;
        end else if (ready && valid) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage PC sequencer and single-outstanding imem request controller.
// Optional feature macro: FETCH_ALIGN_CHK_EN (misaligned redirect targets
// produce an address-fault entry instead of a fetch).
module fetch_ctrl #(
    parameter int                ADDR_W      = fetch_ctrl_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] START_ADDR  = fetch_ctrl_pkg::START_ADDR,
    parameter int                FETCH_BYTES = fetch_ctrl_pkg::FETCH_BYTES
) (
    input  logic                     Clk,
    input  logic                     Rest,
    input  logic                     ctrl_stall,
    input  logic                     ex_redirect,
    input  logic [ADDR_W-1:0]        ex_target,
    input  logic                     br_redirect,
    input  logic [ADDR_W-1:0]        br_target,
    output logic                     imem_req,
    output logic [ADDR_W-1:0]        imem_addr,
    input  logic                     imem_ack,
    input  logic [`FETCH_DATA_W-1:0] imem_rdata,
    output logic                     if_valid,
    output logic [ADDR_W-1:0]        if_pc,
    output logic [`FETCH_DATA_W-1:0] if_inst,
    output logic                     if_adef,
    input  logic                     if_ready
);

    import fetch_ctrl_pkg::*;

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(FETCH_BYTES);

    fetch_state_t       state;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  req_addr;
    logic               redirect;
    logic [ADDR_W-1:0]  raw_target;
    logic [ADDR_W-1:0]  target;
    logic               slot_free;
    logic               issue;
    logic               halt;
    logic               cap_fetch;
    logic               fault_load;
    logic               buf_load;
    logic               buf_adef;
    logic [ADDR_W-1:0]  buf_pc;
    logic [`FETCH_DATA_W-1:0] buf_inst;

    assign redirect   = ex_redirect || br_redirect;
    assign raw_target = ex_redirect ? ex_target : br_target;
    assign slot_free  = !if_valid || if_ready;
    assign issue      = !ctrl_stall && slot_free && !redirect;
    assign imem_addr  = req_addr;
    assign cap_fetch  = (state == REQ) && imem_ack && !redirect;

`ifdef FETCH_ALIGN_CHK_EN
    logic target_bad;
    logic fault_pend;
    logic fault_halt;

    assign target     = raw_target;
    assign target_bad = redirect && (raw_target[1:0] != 2'b00);
    assign halt       = fault_halt;
    assign fault_load = (state == IDLE) && fault_pend && slot_free && !redirect;
    assign buf_adef   = fault_load;

    // A misaligned target arms a one-shot fault entry and parks the fetcher until the next redirect.
    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            fault_pend <= 1'b0;
            fault_halt <= 1'b0;
        end else if (redirect) begin
            fault_pend <= target_bad;
            fault_halt <= target_bad;
        end else if (fault_load) begin
            fault_pend <= 1'b0;
        end
    end
`else
    logic unused_target_lsbs;

    assign unused_target_lsbs = ^raw_target[1:0];
    assign target     = {raw_target[ADDR_W-1:2], 2'b00};
    assign halt       = 1'b0;
    assign fault_load = 1'b0;
    assign buf_adef   = 1'b0;
`endif

    assign buf_load = cap_fetch || fault_load;
    assign buf_pc   = cap_fetch ? req_addr : pc;
    assign buf_inst = cap_fetch ? imem_rdata : '0;

    // Fetch FSM: issues requests, keeps the handshake up through redirects, and steers the PC.
    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            state    <= IDLE;
            pc       <= START_ADDR;
            req_addr <= START_ADDR;
            imem_req <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect) begin
                        pc <= target;
                    end else if (issue && !halt) begin
                        req_addr <= pc;
                        state    <= REQ;
                        imem_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (redirect) begin
                        pc <= target;
                        if (imem_ack) begin
                            state    <= IDLE;
                            imem_req <= 1'b0;
                        end else begin
                            state <= DISCARD;
                        end
                    end else if (imem_ack) begin
                        pc <= req_addr + STEP;
                        if (issue) begin
                            req_addr <= pc + STEP;
                        end else begin
                            state    <= IDLE;
                            imem_req <= 1'b0;
                        end
                    end
                end
                DISCARD: begin
                    if (redirect) begin
                        pc <= target;
                    end
                    if (imem_ack) begin
                        state    <= IDLE;
                        imem_req <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    fetch_out_buf #(
        .AW (ADDR_W),
        .DW (`FETCH_DATA_W)
    ) u_out_buf (
        .clk       (Clk),
        .rst_n     (Rest),
        .flush     (redirect),
        .load      (buf_load),
        .load_pc   (buf_pc),
        .load_inst (buf_inst),
        .load_adef (buf_adef),
        .ready     (if_ready),
        .valid     (if_valid),
        .pc        (if_pc),
        .inst      (if_inst),
        .adef      (if_adef)
    );

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- PC sequencer and instruction-memory request controller for the fetch stage.
- Generates the dual-issue fetch PC, advancing 8 bytes per fetch, and drives a single-outstanding req/ack handshake to instruction memory.
- Applies redirects from branch and exception with exception priority, honours pipeline stall, and holds one fetched pair in an output register for decode.

Parameters:
- ADDR_W, 32, fetch address width.
- START_ADDR, 32'h1C00_0000, PC loaded at reset.
- FETCH_BYTES, 8, PC increment per accepted fetch (two 32-bit instructions).

Ports:
- Clk  in  1  clock, rising edge.
- Rest  in  1  reset, asynchronous, active-low.
- ctrl_stall  in  1  pipeline control: block issue of new fetch requests.
- ex_redirect  in  1  exception/ertn redirect strobe.
- ex_target  in  ADDR_W  exception redirect target.
- br_redirect  in  1  branch-mispredict redirect strobe.
- br_target  in  ADDR_W  branch redirect target.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_W  fetch address, stable while imem_req=1.
- imem_ack  in  1  request accepted; imem_rdata valid this cycle.
- imem_rdata  in  64  instruction pair.
- if_valid  out  1  output register holds a pair.
- if_pc  out  ADDR_W  PC of held pair.
- if_inst  out  64  held pair.
- if_adef  out  1  held entry is an address-fault (see Optional Feature).
- if_ready  in  1  decode consumes the held entry this cycle.

Behaviour:
- Reset (Rest=0, async): state=IDLE, pc=START_ADDR, req_addr=START_ADDR, imem_req=0, imem_addr=START_ADDR, if_valid=0, if_pc=0, if_inst=0, if_adef=0.
- An outstanding transaction at reset is abandoned; imem is reset by the same Rest.
- slot_free = !if_valid || if_ready.
- issue = !ctrl_stall && slot_free && !redirect, where redirect = ex_redirect || br_redirect.
- Redirect target: ex_target if ex_redirect, else br_target. Exception wins when both are asserted.
- States:
  - IDLE:
    - imem_req=0.
    - On redirect: pc<=target, stay in IDLE.
    - Else if issue: req_addr<=pc, go to REQ.
  - REQ:
    - imem_req=1, imem_addr=req_addr.
    - imem_ack may arrive in the first REQ cycle or any later one.
    - ack && !redirect: if_valid<=1, if_pc<=req_addr, if_inst<=imem_rdata, pc<=req_addr+FETCH_BYTES (mod 2^ADDR_W). If issue-conditions still hold (slot treated free, no stall), req_addr<=pc+FETCH_BYTES and stay in REQ (back-to-back, 1 fetch/cycle with 0-latency memory); else go to IDLE.
    - ack && redirect: drop data, pc<=target, go to IDLE.
    - !ack && redirect: pc<=target, go to DISCARD. imem_addr stays at req_addr; the handshake must not be withdrawn.
  - DISCARD:
    - imem_req=1, imem_addr=req_addr (old).
    - A further redirect overwrites pc; latest wins, exception priority within a cycle.
    - On ack: drop data, go to IDLE.
- Output register:
  - if_ready && if_valid with no new capture: if_valid<=0.
  - Any redirect: if_valid<=0 (flush), overriding a same-cycle capture.
  - Capture only occurs when slot_free held at issue. A pending REQ is never entered with the slot occupied and no drain.
- Stall: ctrl_stall does not cancel a pending REQ. It only blocks the next issue; the held entry stays valid.
- pc wrap: 32'hFFFF_FFF8+8 -> 32'h0000_0000, no flag.
- Redirect to IDLE costs 1 bubble cycle before the new request.

Optional Feature:
- Macro FETCH_ALIGN_CHK_EN.
- Enabled:
  - A redirect target with target[1:0]!=0 sets a fault flag. No imem request is issued for it.
  - Next cycle with slot free: if_valid=1, if_adef=1, if_pc=target, if_inst=0.
  - The block then stays in IDLE until the next redirect.
  - START_ADDR is aligned by definition.
- Disabled:
  - Targets are used with bits [1:0] forced to 0.
  - if_adef is tied to 0.

Decomposition:
- Shared package/define file holds:
  - ADDR_W and the 64-bit fetch-data width macro.
  - START_ADDR value and FETCH_BYTES.
  - State encodings IDLE=2'd0, REQ=2'd1, DISCARD=2'd2.
- Natural sub-module: fetch_out_buf, the single-entry valid/ready output register with flush input.
- FSM and PC logic stay in fetch_ctrl.

Test Plan:
- Reset release, ack same cycle as req, if_ready=1, no stall -> imem_addr sequence 1C000000, 1C000008, 1C000010 on consecutive cycles; if_pc follows one cycle later.
- Ack delayed 3 cycles, br_redirect target 1C000100 in cycle 1 of wait -> imem_addr held 1C000000 until ack, data dropped (if_valid stays 0), next request 1C000100.
- ex_redirect=1C008000 and br_redirect=1C000200 in same cycle -> next imem_addr 1C008000.
- if_ready=0 with if_valid=1 -> no new imem_req, if_pc/if_inst stable; raise if_ready -> request resumes at pc+8.
- ctrl_stall=1 while in REQ without ack -> req stays up; ack captured; no further req until stall drops.
- FETCH_ALIGN_CHK_EN: br_target 1C000102 -> no imem_req, if_valid=1, if_adef=1, if_pc=1C000102; disabled build -> fetch at 1C000100.
